// File: rtl/finalproject_led_fader.sv
// Per-LED brightness fader: each channel ramps a PWM level toward its PIO target
// at a divided step rate and is rendered against one shared PWM counter.
module finalproject_led_fader #(
    parameter int N_LEDS   = 14,
    parameter int PWM_BITS = 4,
    parameter int FADE_DIV = 390625
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_in,
    input  logic              bypass,
    output logic [N_LEDS-1:0] led_out,
    output logic              fade_busy
);

    localparam int                PRE_W    = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [N_LEDS-1:0]   led_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] level [N_LEDS];
    logic [N_LEDS-1:0]   render;
    logic [N_LEDS-1:0]   off_target;

    // One fade step toward the target, pinned at 0 and MAX instead of wrapping.
    function automatic logic [PWM_BITS-1:0] step_level(input logic [PWM_BITS-1:0] lv,
                                                        input logic              up);
        if (up && lv != MAX)
            return lv + 1'b1;
        else if (!up && lv != '0)
            return lv - 1'b1;
        else
            return lv;
    endfunction

    assign step_tick = (pre_cnt == PRE_LAST) && !bypass;

    // Input capture and timebases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= '0;
            pwm_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            led_q <= led_in;
            if (bypass) begin
                pwm_cnt <= '0;
                pre_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
                pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            end
        end
    end

    // Level update: bypass forces levels to the rails so fading resumes from there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LEDS; i++)
                level[i] <= '0;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (bypass)
                    level[i] <= led_q[i] ? MAX : '0;
                else if (step_tick)
                    level[i] <= step_level(level[i], led_q[i]);
            end
        end
    end

    always_comb begin
        render     = '0;
        off_target = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            render[i]     = bypass ? led_q[i] : ((level[i] == MAX) || (level[i] > pwm_cnt));
            off_target[i] = (level[i] != (led_q[i] ? MAX : '0));
        end
    end

    // Output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out   <= '0;
            fade_busy <= 1'b0;
        end else begin
            led_out   <= render;
            fade_busy <= |off_target;
        end
    end

endmodule

// File: tb/tb_finalproject_led_fader.sv
// Directed bench for finalproject_led_fader with PWM_BITS=4, FADE_DIV=4.
module tb_finalproject_led_fader;

    logic        clk;
    logic        reset_n;
    logic [13:0] led_in;
    logic        bypass;
    logic [13:0] led_out;
    logic        fade_busy;

    int checks   = 0;
    int failures = 0;

    finalproject_led_fader #(
        .N_LEDS  (14),
        .PWM_BITS(4),
        .FADE_DIV(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .led_in   (led_in),
        .bypass   (bypass),
        .led_out  (led_out),
        .fade_busy(fade_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Hand-derived level after edge k of a phase (edges counted from phase start).
    // mode 0: ramp up from 0; mode 1: up to 6 then target dropped after edge 24;
    // mode 2: ramp down from 15.
    function automatic int lvl(input int mode, input int k);
        int v;
        case (mode)
            0:       v = (k / 4 > 15) ? 15 : k / 4;
            1:       v = (k < 28) ? k / 4 : ((12 - k / 4 > 0) ? 12 - k / 4 : 0);
            default: v = (15 - k / 4 > 0) ? 15 - k / 4 : 0;
        endcase
        return v;
    endfunction

    // Registered target (led_q) after edge k of a phase.
    function automatic bit tgt(input int mode, input int k);
        case (mode)
            0:       return k >= 1;
            1:       return (k >= 1) && (k <= 24);
            default: return k == 0;
        endcase
    endfunction

    task automatic run_phase(input int mode, input int n, input logic [13:0] mask);
        int          l;
        logic [13:0] exp_out;
        logic        exp_busy;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            l        = lvl(mode, k - 1);
            exp_out  = ((l == 15) || (l > ((k - 1) % 16))) ? mask : 14'h0;
            exp_busy = (l != (tgt(mode, k - 1) ? 15 : 0));
            check($sformatf("led_out m%0d k%0d", mode, k), 32'(led_out), 32'(exp_out));
            check($sformatf("fade_busy m%0d k%0d", mode, k), 32'(fade_busy), 32'(exp_busy));
            if (mode == 1 && k == 24)
                led_in = 14'h0000;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bypass  = 1'b0;
        led_in  = 14'h3FFF;
        repeat (3) @(negedge clk);
        check("reset led_out", 32'(led_out), 32'h0);
        check("reset fade_busy", 32'(fade_busy), 32'h0);

        // All channels ramp together: every bit of led_out must match bit 0's duty
        reset_n = 1'b1;
        run_phase(0, 70, 14'h3FFF);

        // Single LED ramp, then asynchronous reset at level 9 off a clock edge
        @(negedge clk);
        reset_n = 1'b0;
        led_in  = 14'h0001;
        @(negedge clk);
        reset_n = 1'b1;
        run_phase(0, 37, 14'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset led_out", 32'(led_out), 32'h0);
        check("async reset fade_busy", 32'(fade_busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Restart from 0, reverse at level 6, ramp back to dark
        run_phase(1, 60, 14'h0001);

        // Bypass passthrough with 2-cycle latency
        bypass = 1'b1;
        led_in = 14'h2AAA;
        @(posedge clk);
        @(negedge clk);
        check("bypass e1 led_out", 32'(led_out), 32'h0);
        check("bypass e1 fade_busy", 32'(fade_busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("bypass e2 led_out", 32'(led_out), 32'h2AAA);
        check("bypass e2 fade_busy", 32'(fade_busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bypass hold%0d led_out", i), 32'(led_out), 32'h2AAA);
            check($sformatf("bypass hold%0d fade_busy", i), 32'(fade_busy), 32'h0);
        end

        // Release bypass with targets off: lit LEDs fade out from MAX
        bypass = 1'b0;
        led_in = 14'h0000;
        run_phase(2, 66, 14'h2AAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
